pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Fetch/pipeline sequencer for the 2-stage (EX/WB) RV32I core.
//  Owns the fetch PC and the valid bits for the EX and WB stages.
//  Handles branch/jump redirect, hazard stalls, halt/resume and the retired-instruction counter.
//  Sits between instruction memory addressing and the instruction_EX / WB pipeline registers in cpu.
// PARAMETERS
//  PC_W       12  fetch PC width, word address (instruction_mem depth 2^PC_W)
//  BOOT_ADDR  0   pc_fetch value after reset
//  MAX_STALL  4   consecutive stall cycles allowed before forced advance
// PORTS
//  clk           in   1     rising-edge clock
//  rst           in   1     async reset, active-high
//  stall_req     in   1     hazard unit: hold EX, bubble WB this cycle
//  br_taken      in   1     EX instruction redirects control flow
//  br_target     in   PC_W  redirect word address, valid with br_taken
//  halt_req      in   1     level: stop fetch and drain the pipe
//  resume        in   1     pulse: leave HALT
//  pc_fetch      out  PC_W  address driven to instruction_mem
//  pc_ex         out  PC_W  PC of the instruction in instruction_EX
//  ex_load       out  1     load enable for instruction_EX / pc_ex
//  ex_valid      out  1     instruction_EX is real; 0 => datapath forces regwrite/gpio_we low
//  wb_valid      out  1     WB stage holds a real instruction
//  halted        out  1     pipe empty, fetch stopped
//  stall_timeout out  1     sticky: MAX_STALL exceeded
//  instret       out  32    retired-instruction count
// BEHAVIOUR
//  Reset (async): pc_fetch=BOOT_ADDR, pc_ex=0, ex_valid=0, wb_valid=0, halted=0,
//   stall_timeout=0, instret=0, stall_cnt=0, state=BOOT. ex_load=0 while rst is high.
//  States: BOOT, RUN, DRAIN, HALT.
//  BOOT: one cycle. ex_load=1, ex_valid<=0, pc_fetch held. Next state is RUN.
//  RUN: evaluated each edge with priority redirect > halt > stall > advance.
//   Redirect (br_taken & ex_valid):
//    pc_fetch<=br_target; ex_valid<=0 (squash the wrong-path fetch).
//    wb_valid<=1, because the branch itself retires. Stall is ignored.
//   Halt (halt_req): ex_load=1, ex_valid<=0, pc_fetch held, wb_valid<=ex_valid. Next state DRAIN.
//   Stall (stall_req & stall_cnt<MAX_STALL):
//    ex_load=0; pc_fetch, pc_ex and ex_valid held; wb_valid<=0; stall_cnt++.
//   Stall timeout (stall_req & stall_cnt==MAX_STALL):
//    stall_timeout<=1, then perform a normal advance.
//   Advance:
//    pc_ex<=pc_fetch; ex_valid<=1; pc_fetch<=pc_fetch+1 (mod 2^PC_W, so 2^PC_W-1 wraps to 0).
//    wb_valid<=ex_valid; stall_cnt<=0.
//  ex_load is combinational: 1 in every RUN case except stall, and 1 in BOOT and DRAIN; 0 in HALT.
//  DRAIN: one cycle. wb_valid<=0, halted<=1, next state HALT.
//  HALT: everything held. On resume: halted<=0, state RUN, ex_valid stays 0.
//   The first fetch after resume uses the held pc_fetch.
//  br_taken while ex_valid=0 is ignored. resume outside HALT is ignored.
//  halt_req in HALT has no effect; a HALT is left only via resume.
//  instret: +1 on every edge where wb_valid=1 is sampled. Wraps 2^32-1 -> 0.
//  Latency: fetch at pc_fetch=N gives pc_ex=N, ex_valid=1 after 1 edge and wb_valid=1 after 2 edges.
//  Reset asserted mid-operation (any state) returns all state to reset values immediately.
// TESTING
//  1 Release rst at edge 0, no stalls.
//    -> edge1 RUN; edge2 pc_ex=0, ex_valid=1, pc_fetch=1.
//    -> edge3 wb_valid=1; edge4 instret=1; edge10 instret=7.
//  2 br_taken=1, br_target=0x200 while pc_ex=5.
//    -> next edge pc_fetch=0x200, ex_valid=0, wb_valid=1.
//    -> following edge pc_ex=0x200, ex_valid=1.
//  3 stall_req high for 2 cycles at pc_fetch=8.
//    -> pc_fetch=8 and pc_ex held for 2 edges, wb_valid=0 for 2 edges, instret frozen, then resumes 9,10.
//  4 stall_req stuck high with MAX_STALL=4.
//    -> 4 held edges, 5th edge advances and stall_timeout=1, which stays 1 until rst.
//  5 halt_req at pc_fetch=0x10.
//    -> DRAIN, then halted=1 after 2 edges with pc_fetch=0x10.
//    -> resume pulse: pc_ex=0x10, ex_valid=1 one edge after leaving HALT.
//  6 Preload pc_fetch=0xFFF by branch; advance -> pc_fetch=0x000.
//    Also assert rst during DRAIN -> outputs at reset values before the next edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch/pipeline sequencer for the 2-stage (EX/WB) RV32I core: owns the fetch PC, the EX/WB
// valid bits, branch redirect, hazard stalls with a timeout, halt/resume and the retired count.
module pc_sequencer #(
    parameter int unsigned       PC_W      = 12,
    parameter logic [PC_W-1:0]   BOOT_ADDR = '0,
    parameter int unsigned       MAX_STALL = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_req,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            halt_req,
    input  logic            resume,
    output logic [PC_W-1:0] pc_fetch,
    output logic [PC_W-1:0] pc_ex,
    output logic            ex_load,
    output logic            ex_valid,
    output logic            wb_valid,
    output logic            halted,
    output logic            stall_timeout,
    output logic [31:0]     instret
);

    localparam int unsigned CntW = $clog2(MAX_STALL + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_STALL);

    typedef enum logic [1:0] {StBoot, StRun, StDrain, StHalt} state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_fetch_q, pc_fetch_d;
    logic [PC_W-1:0] pc_ex_q, pc_ex_d;
    logic            ex_valid_q, ex_valid_d;
    logic            wb_valid_q, wb_valid_d;
    logic            halted_q, halted_d;
    logic            timeout_q, timeout_d;
    logic [CntW-1:0] stall_cnt_q, stall_cnt_d;
    logic [31:0]     instret_q;
    logic            load;

    always_comb begin
        state_d     = state_q;
        pc_fetch_d  = pc_fetch_q;
        pc_ex_d     = pc_ex_q;
        ex_valid_d  = ex_valid_q;
        wb_valid_d  = wb_valid_q;
        halted_d    = halted_q;
        timeout_d   = timeout_q;
        stall_cnt_d = stall_cnt_q;
        load        = 1'b0;
        unique case (state_q)
            StBoot: begin
                load       = 1'b1;
                ex_valid_d = 1'b0;
                wb_valid_d = 1'b0;
                state_d    = StRun;
            end
            StRun: begin
                load = 1'b1;
                if (br_taken && ex_valid_q) begin
                    // Squash the wrong-path fetch; the branch itself still retires.
                    pc_fetch_d  = br_target;
                    ex_valid_d  = 1'b0;
                    wb_valid_d  = 1'b1;
                    stall_cnt_d = '0;
                end else if (halt_req) begin
                    ex_valid_d  = 1'b0;
                    wb_valid_d  = ex_valid_q;
                    stall_cnt_d = '0;
                    state_d     = StDrain;
                end else if (stall_req && (stall_cnt_q < MaxCnt)) begin
                    load        = 1'b0;
                    wb_valid_d  = 1'b0;
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end else begin
                    if (stall_req) begin
                        timeout_d = 1'b1;
                    end
                    pc_fetch_d  = pc_fetch_q + PC_W'(1);
                    ex_valid_d  = 1'b1;
                    wb_valid_d  = ex_valid_q;
                    stall_cnt_d = '0;
                end
            end
            StDrain: begin
                load       = 1'b1;
                wb_valid_d = 1'b0;
                halted_d   = 1'b1;
                state_d    = StHalt;
            end
            StHalt: begin
                if (resume) begin
                    halted_d = 1'b0;
                    state_d  = StRun;
                end
            end
            default: state_d = StBoot;
        endcase
        if (load) begin
            pc_ex_d = pc_fetch_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StBoot;
            pc_fetch_q  <= BOOT_ADDR;
            pc_ex_q     <= '0;
            ex_valid_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_fetch_q  <= pc_fetch_d;
            pc_ex_q     <= pc_ex_d;
            ex_valid_q  <= ex_valid_d;
            wb_valid_q  <= wb_valid_d;
            halted_q    <= halted_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            if (wb_valid_q) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign ex_load       = load & ~rst;
    assign pc_fetch      = pc_fetch_q;
    assign pc_ex         = pc_ex_q;
    assign ex_valid      = ex_valid_q;
    assign wb_valid      = wb_valid_q;
    assign halted        = halted_q;
    assign stall_timeout = timeout_q;
    assign instret       = instret_q;

endmodule
